emesh_txwr_fifo: RTL and testbench

Synchronous 104-bit emesh packet buffer that sits directly upstream of the elink `txwr_*` system interface. It accepts write packets from the host/fabric side, stores up to `DEPTH` packets, and presents them first-word-fall-through to the elink transmit-write port. It absorbs `txwr_wait` backpressure from the elink and propagates backpressure upstream only when storage is full.

---
 rtl/emesh_txwr_fifo.sv | 64 ++++++
 tb/tb_emesh_txwr_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/emesh_txwr_fifo.sv
// rtl/emesh_txwr_fifo.sv - first-word-fall-through emesh packet buffer ahead of elink txwr
// Optional macro EMESH_TXWR_FIFO_STATS_EN adds the pkt_total transferred-packet counter.
module emesh_txwr_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_access,
  input  logic [103:0]  in_packet,
  output logic          in_wait,
  output logic          out_access,
  output logic [103:0]  out_packet,
  input  logic          out_wait,
`ifdef EMESH_TXWR_FIFO_STATS_EN
  output logic [31:0]   pkt_total,
`endif
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [103:0] mem [DEPTH];
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // Extra pointer bit distinguishes full from empty; flags decode registered state only.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign in_wait    = full;
  assign out_access = ~empty;
  assign push       = in_access & ~full;
  assign pop        = ~empty & ~out_wait;
  assign out_packet = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_packet;
  end

`ifdef EMESH_TXWR_FIFO_STATS_EN
  always_ff @(posedge clock) begin
    if (reset)    pkt_total <= '0;
    else if (pop) pkt_total <= pkt_total + 32'd1;
  end
`endif

endmodule

// File: tb/tb_emesh_txwr_fifo.sv
// tb/tb_emesh_txwr_fifo.sv - directed and randomized checks of emesh_txwr_fifo against a queue model
module tb_emesh_txwr_fifo;

  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);

  logic          clock;
  logic          reset;
  logic          in_access;
  logic [103:0]  in_packet;
  logic          in_wait;
  logic          out_access;
  logic [103:0]  out_packet;
  logic          out_wait;
  logic [AW:0]   count;
`ifdef EMESH_TXWR_FIFO_STATS_EN
  logic [31:0]   pkt_total;
`endif

  int checks = 0;
  int errors = 0;
  logic [103:0] q[$];
  int unsigned exp_total = 0;

  emesh_txwr_fifo #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .in_access(in_access),
    .in_packet(in_packet),
    .in_wait(in_wait),
    .out_access(out_access),
    .out_packet(out_packet),
    .out_wait(out_wait),
`ifdef EMESH_TXWR_FIFO_STATS_EN
    .pkt_total(pkt_total),
`endif
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [103:0] mk(input int i);
    return {32'h0000_1000, 32'(i), 32'h8000_0000, 8'h05};
  endfunction

  function automatic logic [103:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, 8'($urandom)};
  endfunction

  // Drives one cycle and advances the reference queue by the transfer rule.
  task automatic advance(input logic ia, input logic [103:0] pkt, input logic ow, output logic acc);
    logic pop;
    logic [103:0] gone;
    in_access = ia;
    in_packet = pkt;
    out_wait  = ow;
    acc = ia && (q.size() < DEPTH);
    pop = (q.size() > 0) && !ow;
    @(posedge clock); #1;
    if (pop) begin
      gone = q.pop_front();
      exp_total++;
    end
    if (acc) q.push_back(pkt);
  endtask

  task automatic do_reset(input int n, input logic ia);
    in_access = ia;
    in_packet = rnd_pkt();
    out_wait  = 1'b0;
    reset     = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    in_access = 1'b0;
    q.delete();
    exp_total = 0;
  endtask

  task automatic test_reset();
    logic acc;
    do_reset(2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_access !== 1'b0) begin errors++; $display("FAIL reset_out_access got %b exp 0", out_access); end
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL reset_in_wait got %b exp 0", in_wait); end
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      advance(1'b0, '0, 1'b0, acc);
    end
`ifdef EMESH_TXWR_FIFO_STATS_EN
    checks++; if (pkt_total !== 32'd0) begin errors++; $display("FAIL reset_pkt_total got %0d exp 0", pkt_total); end
`endif
  endtask

  task automatic test_single();
    logic acc;
    logic [103:0] pkt;
    pkt = {32'h0000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 5'h00, 2'b10, 1'b1};
    do_reset(2, 1'b0);
    advance(1'b1, pkt, 1'b0, acc);
    checks++; if (out_access !== 1'b1) begin errors++; $display("FAIL single_out_access got %b exp 1", out_access); end
    checks++; if (out_packet !== pkt) begin errors++; $display("FAIL single_packet got %h exp %h", out_packet, pkt); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", count); end
    advance(1'b0, '0, 1'b0, acc);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", count); end
    checks++; if (out_access !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", out_access); end
`ifdef EMESH_TXWR_FIFO_STATS_EN
    checks++; if (pkt_total !== 32'd1) begin errors++; $display("FAIL single_pkt_total got %0d exp 1", pkt_total); end
`endif
  endtask

  task automatic test_fill();
    logic acc;
    int nin;
    int nout;
    logic first;
    do_reset(2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL fill_wait_early push %0d got %b exp 0", i, in_wait); end
      advance(1'b1, mk(i), 1'b1, acc);
    end
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL fill_wait_full got %b exp 1", in_wait); end
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
      checks++; if (out_packet !== mk(0)) begin errors++; $display("FAIL fill_head got %h exp %h", out_packet, mk(0)); end
      advance(1'b1, mk(8), 1'b1, acc);
    end
    nin = 8;
    nout = 0;
    first = 1'b1;
    for (int c = 0; c < 40 && nout < 10; c++) begin
      checks++; if (out_access !== 1'b1 || out_packet !== mk(nout)) begin
        errors++; $display("FAIL fill_order idx %0d got %b/%h exp 1/%h", nout, out_access, out_packet, mk(nout));
      end
      advance(nin < 10, mk(nin), 1'b0, acc);
      if (acc) nin++;
      nout++;
      if (first) begin
        first = 1'b0;
        checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL fill_release_wait got %b exp 0", in_wait); end
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL fill_release_count got %0d exp 7", count); end
      end
    end
    checks++; if (nout !== 10 || count !== 4'd0) begin errors++; $display("FAIL fill_drain got %0d/%0d exp 10/0", nout, count); end
  endtask

  task automatic test_simul();
    logic acc;
    int nin;
    int nout;
    do_reset(2, 1'b0);
    for (int i = 0; i < 4; i++) advance(1'b1, mk(i), 1'b1, acc);
    nin = 4;
    nout = 0;
    for (int c = 0; c < 3*DEPTH + 4; c++) begin
      checks++; if (count !== 4'd4) begin errors++; $display("FAIL simul_count got %0d exp 4", count); end
      checks++; if (out_packet !== mk(nout)) begin errors++; $display("FAIL simul_order got %h exp %h", out_packet, mk(nout)); end
      advance(1'b1, mk(nin), 1'b0, acc);
      nin++;
      nout++;
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic [103:0] pkt;
    do_reset(2, 1'b0);
    for (int i = 0; i < 5; i++) advance(1'b1, mk(100 + i), 1'b1, acc);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count); end
    do_reset(1, 1'b1);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
    checks++; if (out_access !== 1'b0) begin errors++; $display("FAIL mid_out_access got %b exp 0", out_access); end
    checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL mid_in_wait got %b exp 0", in_wait); end
    pkt = mk(777);
    advance(1'b1, pkt, 1'b0, acc);
    checks++; if (out_access !== 1'b1 || out_packet !== pkt) begin
      errors++; $display("FAIL mid_first_out got %b/%h exp 1/%h", out_access, out_packet, pkt);
    end
  endtask

  task automatic test_random();
    logic acc;
    logic ia;
    logic ow;
    logic hold;
    logic [103:0] pend;
    do_reset(2, 1'b0);
    pend = rnd_pkt();
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      ia = hold || ($urandom_range(99) < 70);
      ow = 1'($urandom_range(1));
      checks++; if (count !== (AW+1)'(q.size()) || count > 4'd8) begin errors++; $display("FAIL rnd_count got %0d exp %0d", count, q.size()); end
      checks++; if (in_wait !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_in_wait got %b exp %b", in_wait, q.size() == DEPTH); end
      checks++; if (out_access !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_access got %b exp %b", out_access, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (out_packet !== q[0]) begin errors++; $display("FAIL rnd_head got %h exp %h", out_packet, q[0]); end
      end
      advance(ia, pend, ow, acc);
      hold = ia && !acc;
      if (acc) pend = rnd_pkt();
    end
`ifdef EMESH_TXWR_FIFO_STATS_EN
    checks++; if (pkt_total !== exp_total) begin errors++; $display("FAIL rnd_pkt_total got %0d exp %0d", pkt_total, exp_total); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    in_access = 1'b0;
    in_packet = '0;
    out_wait = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
